pixel_readout_capture: RTL and testbench

- Downstream of camera_controller.
- Watches the readout strobes camera_controller drives (NRE_1, NRE_2, ADC) and captures the two-column ADC results for each row of the 2x2 pixel array.
- Once both rows of a frame are captured, it transfers the four pixels to an output buffer and streams them over a valid/ready interface to the image sink.
- Frames that complete while the previous frame is still draining are dropped and flagged.

---
 rtl/pixel_readout_capture_if.sv | 27 ++
 rtl/pixel_readout_capture.sv | 135 +++++++++++++
 tb/tb_pixel_readout_capture.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_readout_capture_if.sv
// Pixel stream interface between pixel_readout_capture and the image sink.
//   pix_valid : source -> sink, pix_data/pix_index are valid
//   pix_data  : source -> sink, pixel value (DATA_W bits)
//   pix_index : source -> sink, pixel position 0=r1c1 1=r1c2 2=r2c1 3=r2c2
//   pix_ready : sink -> source, sink accepts the current word
interface pixel_readout_capture_if #(
    parameter int DATA_W = 8
);
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic [1:0]        pix_index;
    logic              pix_ready;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_index,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_index,
        output pix_ready
    );
endinterface

// File: rtl/pixel_readout_capture.sv
// Captures the two-column ADC results of a 2x2 pixel array as the
// camera_controller strobes each row, then streams each complete frame
// out over a valid/ready interface.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   NRE_1, NRE_2       : active-low row read enables
//   ADC                : conversion strobe, rising edge captures a row
//   expose             : rising edge starts a new frame (drops partial rows)
//   adc_col1, adc_col2 : ADC results for columns 1 and 2
//   pix                : pixel stream (master side)
//   frame_done         : pulse, complete frame loaded for draining
//   frame_drop         : pulse, complete frame discarded (drain busy)
//   seq_err            : pulse, ADC edge with illegal NRE combination
module pixel_readout_capture #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              NRE_1,
    input  logic              NRE_2,
    input  logic              ADC,
    input  logic              expose,
    input  logic [DATA_W-1:0] adc_col1,
    input  logic [DATA_W-1:0] adc_col2,
    pixel_readout_capture_if.master pix,
    output logic              frame_done,
    output logic              frame_drop,
    output logic              seq_err
);
    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                  state;
    logic                    adc_q;
    logic                    expose_q;
    logic                    row1_flag;
    logic                    row2_flag;
    logic [3:0][DATA_W-1:0]  cap;
    logic [3:0][DATA_W-1:0]  obuf;
    logic [1:0]              idx;
    logic [DATA_W-1:0]       data_q;

    logic                    adc_edge;
    logic                    exp_edge;
    logic                    row1_hit;
    logic                    row2_hit;
    logic                    illegal;
    logic                    row1_n;
    logic                    row2_n;
    logic                    complete;
    logic                    accept;
    logic                    last;
    logic                    can_load;
    logic [3:0][DATA_W-1:0]  cap_n;

    assign adc_edge = ADC & ~adc_q;
    assign exp_edge = expose & ~expose_q;
    assign row1_hit = adc_edge & ~NRE_1 &  NRE_2;
    assign row2_hit = adc_edge &  NRE_1 & ~NRE_2;
    assign illegal  = adc_edge & (NRE_1 == NRE_2);

    // Expose clears the flags before a same-cycle capture sets its row again.
    assign row1_n   = (row1_flag & ~exp_edge) | row1_hit;
    assign row2_n   = (row2_flag & ~exp_edge) | row2_hit;
    assign complete = row1_n & row2_n;

    assign accept   = (state == DRAIN) & pix.pix_ready;
    assign last     = accept & (idx == 2'd3);
    assign can_load = (state == IDLE) | last;

    // Next capture contents, so a completing row is copied out in the same cycle.
    always_comb begin
        cap_n = cap;
        if (row1_hit) begin
            cap_n[0] = adc_col1;
            cap_n[1] = adc_col2;
        end
        if (row2_hit) begin
            cap_n[2] = adc_col1;
            cap_n[3] = adc_col2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            adc_q      <= 1'b0;
            expose_q   <= 1'b0;
            row1_flag  <= 1'b0;
            row2_flag  <= 1'b0;
            cap        <= '0;
            obuf       <= '0;
            idx        <= '0;
            data_q     <= '0;
            frame_done <= 1'b0;
            frame_drop <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            adc_q      <= ADC;
            expose_q   <= expose;
            cap        <= cap_n;
            seq_err    <= illegal;
            frame_done <= 1'b0;
            frame_drop <= 1'b0;
            row1_flag  <= row1_n & ~complete;
            row2_flag  <= row2_n & ~complete;

            if (complete && can_load) begin
                // Covers both an idle load and a back-to-back reload on the final handshake.
                obuf       <= cap_n;
                state      <= DRAIN;
                idx        <= 2'd0;
                data_q     <= cap_n[0];
                frame_done <= 1'b1;
            end else begin
                if (complete) begin
                    frame_drop <= 1'b1;
                end
                if (state == DRAIN && accept) begin
                    if (last) begin
                        state  <= IDLE;
                        idx    <= 2'd0;
                        data_q <= '0;
                    end else begin
                        idx    <= idx + 2'd1;
                        data_q <= obuf[idx + 2'd1];
                    end
                end
            end
        end
    end

    assign pix.pix_valid = (state == DRAIN);
    assign pix.pix_data  = data_q;
    assign pix.pix_index = idx;
endmodule

// File: tb/tb_pixel_readout_capture.sv
// Directed bench for pixel_readout_capture: stimulus in one initial block,
// expected pixels queued when a frame is completed and checked on handshake.
module tb_pixel_readout_capture;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] idx;
    } pix_t;

    logic              clk;
    logic              rst;
    logic              NRE_1;
    logic              NRE_2;
    logic              ADC;
    logic              expose;
    logic [DATA_W-1:0] adc_col1;
    logic [DATA_W-1:0] adc_col2;
    logic              frame_done;
    logic              frame_drop;
    logic              seq_err;

    pixel_readout_capture_if #(.DATA_W(DATA_W)) pix_bus ();

    pixel_readout_capture #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .NRE_1      (NRE_1),
        .NRE_2      (NRE_2),
        .ADC        (ADC),
        .expose     (expose),
        .adc_col1   (adc_col1),
        .adc_col2   (adc_col2),
        .pix        (pix_bus),
        .frame_done (frame_done),
        .frame_drop (frame_drop),
        .seq_err    (seq_err)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    int   done_cnt    = 0;
    int   drop_cnt    = 0;
    int   err_cnt     = 0;
    int   hs_cnt      = 0;
    int   exp_done    = 0;
    int   exp_drop    = 0;
    int   exp_err     = 0;
    pix_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Rising ADC edge captured at the posedge inside this task; returns just after it.
    task automatic adc_pulse(input logic n1, input logic n2, input logic [7:0] c1, input logic [7:0] c2);
        step();
        NRE_1    = n1;
        NRE_2    = n2;
        adc_col1 = c1;
        adc_col2 = c2;
        ADC      = 1'b1;
        step();
        ADC      = 1'b0;
    endtask

    task automatic exp_pulse();
        step();
        expose = 1'b1;
        step();
        expose = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        sb.push_back('{data: a, idx: 2'd0});
        sb.push_back('{data: b, idx: 2'd1});
        sb.push_back('{data: c, idx: 2'd2});
        sb.push_back('{data: d, idx: 2'd3});
        exp_done++;
    endtask

    task automatic drain_wait(input string tag);
        for (int i = 0; i < 60 && sb.size() != 0; i++) step();
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard and pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) done_cnt++;
            if (frame_drop) drop_cnt++;
            if (seq_err)    err_cnt++;
            if (pix_bus.pix_valid && pix_bus.pix_ready) begin
                pix_t e;
                hs_cnt++;
                chk("word_expected", {31'b0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("pix_data", 32'(pix_bus.pix_data), 32'(e.data));
                    chk("pix_index", 32'(pix_bus.pix_index), 32'(e.idx));
                end
            end
        end
    end

    initial begin
        int hs0;
        rst = 1'b1;
        NRE_1 = 1'b1;
        NRE_2 = 1'b1;
        ADC = 1'b0;
        expose = 1'b0;
        adc_col1 = '0;
        adc_col2 = '0;
        pix_bus.pix_ready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_valid", 32'(pix_bus.pix_valid), 32'd0);
        chk("rst_data", 32'(pix_bus.pix_data), 32'd0);
        chk("rst_index", 32'(pix_bus.pix_index), 32'd0);
        chk("rst_pulses", {29'b0, frame_done, frame_drop, seq_err}, 32'd0);
        step();
        rst = 1'b0;

        // Basic frame with sink always ready
        pix_bus.pix_ready = 1'b1;
        hs0 = hs_cnt;
        exp_pulse();
        adc_pulse(1'b0, 1'b1, 8'h11, 8'h22);
        push_frame(8'h11, 8'h22, 8'h33, 8'h44);
        adc_pulse(1'b1, 1'b0, 8'h33, 8'h44);
        @(negedge clk);
        chk("basic_done", 32'(frame_done), 32'd1);
        chk("basic_valid", 32'(pix_bus.pix_valid), 32'd1);
        chk("basic_index0", 32'(pix_bus.pix_index), 32'd0);
        chk("basic_data0", 32'(pix_bus.pix_data), 32'h11);
        drain_wait("basic_drain");
        @(negedge clk);
        chk("basic_idle", 32'(pix_bus.pix_valid), 32'd0);
        chk("basic_hs", 32'(hs_cnt - hs0), 32'd4);

        // Backpressure: stall 5 cycles, then alternate ready
        step();
        pix_bus.pix_ready = 1'b0;
        hs0 = hs_cnt;
        exp_pulse();
        adc_pulse(1'b0, 1'b1, 8'h11, 8'h22);
        push_frame(8'h11, 8'h22, 8'h33, 8'h44);
        adc_pulse(1'b1, 1'b0, 8'h33, 8'h44);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(pix_bus.pix_valid), 32'd1);
            chk("stall_data", 32'(pix_bus.pix_data), 32'h11);
            chk("stall_index", 32'(pix_bus.pix_index), 32'd0);
        end
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            step();
            pix_bus.pix_ready = (i % 2 == 0);
        end
        chk("bp_drain", 32'(sb.size()), 32'd0);
        chk("bp_hs", 32'(hs_cnt - hs0), 32'd4);
        pix_bus.pix_ready = 1'b0;
        step();
        @(negedge clk);
        chk("bp_idle", 32'(pix_bus.pix_valid), 32'd0);

        // Drop: frame B completes while frame A is stalled
        step();
        exp_pulse();
        adc_pulse(1'b0, 1'b1, 8'h01, 8'h02);
        push_frame(8'h01, 8'h02, 8'h03, 8'h04);
        adc_pulse(1'b1, 1'b0, 8'h03, 8'h04);
        adc_pulse(1'b0, 1'b1, 8'hA1, 8'hA2);
        adc_pulse(1'b1, 1'b0, 8'hA3, 8'hA4);
        exp_drop++;
        @(negedge clk);
        chk("drop_pulse", 32'(frame_drop), 32'd1);
        chk("drop_keep_data", 32'(pix_bus.pix_data), 32'h01);
        step();
        pix_bus.pix_ready = 1'b1;
        drain_wait("drop_drain");
        @(negedge clk);
        chk("drop_idle", 32'(pix_bus.pix_valid), 32'd0);

        // Back-to-back: B completes on the cycle A's index 3 is accepted
        exp_pulse();
        adc_pulse(1'b0, 1'b1, 8'hB1, 8'hB2);
        push_frame(8'hB1, 8'hB2, 8'hB3, 8'hB4);
        adc_pulse(1'b1, 1'b0, 8'hB3, 8'hB4);
        push_frame(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        adc_pulse(1'b0, 1'b1, 8'hC1, 8'hC2);
        adc_pulse(1'b1, 1'b0, 8'hC3, 8'hC4);
        @(negedge clk);
        chk("b2b_done", 32'(frame_done), 32'd1);
        chk("b2b_nodrop", 32'(frame_drop), 32'd0);
        chk("b2b_valid", 32'(pix_bus.pix_valid), 32'd1);
        chk("b2b_index", 32'(pix_bus.pix_index), 32'd0);
        chk("b2b_data", 32'(pix_bus.pix_data), 32'hC1);
        drain_wait("b2b_drain");

        // Sequence errors and restart
        adc_pulse(1'b0, 1'b0, 8'h55, 8'h66);
        exp_err++;
        @(negedge clk);
        chk("seq_err_low", 32'(seq_err), 32'd1);
        adc_pulse(1'b1, 1'b1, 8'h77, 8'h88);
        exp_err++;
        @(negedge clk);
        chk("seq_err_high", 32'(seq_err), 32'd1);
        adc_pulse(1'b0, 1'b1, 8'h12, 8'h34);
        exp_pulse();
        adc_pulse(1'b1, 1'b0, 8'h56, 8'h78);
        @(negedge clk);
        chk("restart_no_done", 32'(frame_done), 32'd0);
        chk("restart_idle", 32'(pix_bus.pix_valid), 32'd0);

        // Reset mid-drain at pix_index 2
        pix_bus.pix_ready = 1'b0;
        exp_pulse();
        adc_pulse(1'b0, 1'b1, 8'hD1, 8'hD2);
        push_frame(8'hD1, 8'hD2, 8'hD3, 8'hD4);
        adc_pulse(1'b1, 1'b0, 8'hD3, 8'hD4);
        pix_bus.pix_ready = 1'b1;
        step();
        step();
        pix_bus.pix_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_index", 32'(pix_bus.pix_index), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_valid", 32'(pix_bus.pix_valid), 32'd0);
        chk("mid_rst_index", 32'(pix_bus.pix_index), 32'd0);
        chk("mid_rst_data", 32'(pix_bus.pix_data), 32'd0);

        pix_bus.pix_ready = 1'b1;
        exp_pulse();
        adc_pulse(1'b0, 1'b1, 8'hE1, 8'hE2);
        push_frame(8'hE1, 8'hE2, 8'hE3, 8'hE4);
        adc_pulse(1'b1, 1'b0, 8'hE3, 8'hE4);
        drain_wait("post_rst_drain");
        @(negedge clk);
        chk("post_rst_idle", 32'(pix_bus.pix_valid), 32'd0);

        chk("done_count", 32'(done_cnt), 32'(exp_done));
        chk("drop_count", 32'(drop_cnt), 32'(exp_drop));
        chk("seq_err_count", 32'(err_cnt), 32'(exp_err));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case a wait above never returns.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
